// File: rtl/hub75_pkg.sv
// hub75_pkg
//   Shared definitions for the HUB75 frame-buffer arbiter:
//   - fb_state_t : arbiter FSM state encoding
//   - req_idx_t  : requester index (readout vs. writer), also used for the
//                  round-robin "last served" memory.
package hub75_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_RD = 2'd1,
    OWN_WR = 2'd2,
    TURN   = 2'd3
  } fb_state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_idx_t;

endpackage

// File: rtl/hub75_fb_if.sv
// hub75_fb_if
//   Bundles the two requester handshakes, the writer access lines and the
//   muxed frame-buffer port.
//   master : requester/frame-buffer side (drives req/rel/addr/write lines,
//            observes grants, muxed port and timeout_err)
//   slave  : arbiter side
interface hub75_fb_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
);
  localparam int MASK_WIDTH = DATA_WIDTH / 4;

  logic                  rd_req;
  logic                  rd_gnt;
  logic                  rd_rel;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  wr_req;
  logic                  wr_gnt;
  logic                  wr_rel;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] wr_mask;
  logic                  wr_ena;

  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0] fb_wr_data;
  logic [MASK_WIDTH-1:0] fb_wr_mask;
  logic                  fb_wr_ena;

  logic                  timeout_err;

  modport master (
    output rd_req, rd_rel, rd_addr,
    output wr_req, wr_rel, wr_addr, wr_data, wr_mask, wr_ena,
    input  rd_gnt, wr_gnt,
    input  fb_addr, fb_wr_data, fb_wr_mask, fb_wr_ena,
    input  timeout_err
  );

  modport slave (
    input  rd_req, rd_rel, rd_addr,
    input  wr_req, wr_rel, wr_addr, wr_data, wr_mask, wr_ena,
    output rd_gnt, wr_gnt,
    output fb_addr, fb_wr_data, fb_wr_mask, fb_wr_ena,
    output timeout_err
  );

endinterface

// File: rtl/hub75_rr_arb2.sv
// hub75_rr_arb2
//   Two-way round-robin pick between the readout and writer requesters.
//   Ports:
//     req_rd, req_wr : request levels
//     last           : requester served most recently
//     valid          : at least one request present
//     pick           : chosen requester (meaningful only when valid)
module hub75_rr_arb2
  import hub75_pkg::*;
(
  input  logic     req_rd,
  input  logic     req_wr,
  input  req_idx_t last,
  output logic     valid,
  output req_idx_t pick
);

  always_comb begin
    valid = req_rd | req_wr;
    pick  = REQ_RD;
    if (req_rd && req_wr) begin
      // contention: the one not served last wins
      pick = (last == REQ_RD) ? REQ_WR : REQ_RD;
    end else if (req_wr) begin
      pick = REQ_WR;
    end
  end

endmodule

// File: rtl/hub75_fb_arbiter.sv
// hub75_fb_arbiter
//   Arbitrates a single frame-buffer port between a read-only readout engine
//   and a writer. Ownership is granted with a one-cycle registered gnt pulse,
//   held until the owner pulses rel (or the hold timer expires), and always
//   followed by one dead TURN cycle.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     bus (slave)  : requester handshakes, writer lines, muxed frame-buffer
//                    port and timeout_err pulse
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | nobody owns the buffer; pending requests are arbitrated
//   OWN_RD | readout engine owns the buffer (address only, no writes)
//   OWN_WR | writer owns the buffer; write lines pass through
//   TURN   | single dead cycle after a release before the next grant
module hub75_fb_arbiter
  import hub75_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input logic       clk,
  input logic       rst_n,
  hub75_fb_if.slave bus
);

  localparam int MASK_WIDTH = DATA_WIDTH / 4;
  localparam int CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

  fb_state_t             state_q, state_d;
  req_idx_t              last_q, last_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic                  wr_gnt_q, wr_gnt_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_W-1:0]      hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [ADDR_WIDTH-1:0] fb_addr_c;
  logic                  owner_rel;
  logic                  arb_valid;
  req_idx_t              arb_pick;

  hub75_rr_arb2 u_rr (
    .req_rd (bus.rd_req),
    .req_wr (bus.wr_req),
    .last   (last_q),
    .valid  (arb_valid),
    .pick   (arb_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= REQ_WR;  // so the readout engine wins the first contention
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      tmo_q       <= 1'b0;
      hold_q      <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rd_gnt_q    <= rd_gnt_d;
      wr_gnt_q    <= wr_gnt_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      addr_hold_q <= fb_addr_c;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rd_gnt_d  = 1'b0;
    wr_gnt_d  = 1'b0;
    tmo_d     = 1'b0;
    hold_d    = hold_q;
    owner_rel = 1'b0;

    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (arb_valid) begin
          last_d = arb_pick;
          if (arb_pick == REQ_RD) begin
            state_d  = OWN_RD;
            rd_gnt_d = 1'b1;
          end else begin
            state_d  = OWN_WR;
            wr_gnt_d = 1'b1;
          end
        end
      end

      OWN_RD, OWN_WR: begin
        // only the current owner can release; the other rel is ignored
        owner_rel = (state_q == OWN_RD) ? bus.rd_rel : bus.wr_rel;
        if (owner_rel) begin
          state_d = TURN;
        end else if (hold_q == HOLD_LAST) begin
          state_d = TURN;
          tmo_d   = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      TURN: begin
        state_d = IDLE;
        hold_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address follows the owner combinationally so the gnt cycle already
  // presents the owner's address; otherwise the last driven value is held.
  always_comb begin
    case (state_q)
      OWN_RD:  fb_addr_c = bus.rd_addr;
      OWN_WR:  fb_addr_c = bus.wr_addr;
      default: fb_addr_c = addr_hold_q;
    endcase
  end

  // Write lines are gated on the state register only, so an asynchronous
  // reset kills fb_wr_ena in the same instant.
  assign bus.fb_addr     = fb_addr_c;
  assign bus.fb_wr_ena   = (state_q == OWN_WR) ? bus.wr_ena  : 1'b0;
  assign bus.fb_wr_data  = (state_q == OWN_WR) ? bus.wr_data : '0;
  assign bus.fb_wr_mask  = (state_q == OWN_WR) ? bus.wr_mask : {MASK_WIDTH{1'b0}};
  assign bus.rd_gnt      = rd_gnt_q;
  assign bus.wr_gnt      = wr_gnt_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
module tb_hub75_fb_arbiter;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hub75_fb_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) bus ();
  hub75_fb_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) bus16 ();

  hub75_fb_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  hub75_fb_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .TIMEOUT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  // advance to 2 time units after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_req = 0; bus.rd_rel = 0; bus.rd_addr = '0;
    bus.wr_req = 0; bus.wr_rel = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.wr_mask = '0; bus.wr_ena = 0;
    bus16.rd_req = 0; bus16.rd_rel = 0; bus16.rd_addr = '0;
    bus16.wr_req = 0; bus16.wr_rel = 0; bus16.wr_addr = '0;
    bus16.wr_data = '0; bus16.wr_mask = '0; bus16.wr_ena = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (bus.rd_gnt !== 1'b0 || bus.wr_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", bus.rd_gnt, bus.wr_gnt); end
    checks++; if (bus.fb_wr_ena !== 1'b0) begin failures++; $display("FAIL reset_wr_ena got=%b exp=0", bus.fb_wr_ena); end
    checks++; if (bus.fb_addr !== 13'h0) begin failures++; $display("FAIL reset_fb_addr got=%h exp=0", bus.fb_addr); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); end
    checks++; if (bus.fb_wr_data !== 16'h0 || bus.fb_wr_mask !== 4'h0) begin failures++; $display("FAIL reset_wr_data got=%h/%h exp=0/0", bus.fb_wr_data, bus.fb_wr_mask); end
    rst_n = 1;
    step();
  endtask

  task automatic test_round_robin();
    bus.rd_req = 1; bus.wr_req = 1;
    step();
    checks++; if (bus.rd_gnt !== 1'b1 || bus.wr_gnt !== 1'b0) begin failures++; $display("FAIL rr_first_rd got=%b%b exp=10", bus.rd_gnt, bus.wr_gnt); end
    // release in the gnt cycle itself
    bus.rd_req = 0; bus.rd_rel = 1;
    step();
    checks++; if (dut.state_q !== TURN) begin failures++; $display("FAIL rr_rel_in_gnt_cycle got=%0d exp=%0d", dut.state_q, TURN); end
    bus.rd_rel = 0; bus.rd_req = 1;
    step();
    checks++; if (dut.state_q !== IDLE || bus.wr_gnt !== 1'b0) begin failures++; $display("FAIL rr_turn_dead got=%0d/%b exp=%0d/0", dut.state_q, bus.wr_gnt, IDLE); end
    step();
    checks++; if (bus.wr_gnt !== 1'b1 || bus.rd_gnt !== 1'b0) begin failures++; $display("FAIL rr_second_wr got=%b%b exp=01", bus.rd_gnt, bus.wr_gnt); end
    bus.wr_req = 0; bus.wr_rel = 1;
    step();
    bus.wr_rel = 0; bus.wr_req = 1;
    step();
    step();
    checks++; if (bus.rd_gnt !== 1'b1 || bus.wr_gnt !== 1'b0) begin failures++; $display("FAIL rr_third_rd got=%b%b exp=10", bus.rd_gnt, bus.wr_gnt); end
    bus.rd_req = 0; bus.rd_rel = 1;
    step();
    bus.rd_rel = 0;
    step();
    step();
    checks++; if (bus.wr_gnt !== 1'b1 || dut.state_q !== OWN_WR) begin failures++; $display("FAIL rr_queued_wr got=%b/%0d exp=1/%0d", bus.wr_gnt, dut.state_q, OWN_WR); end
    bus.wr_req = 0; bus.wr_rel = 1;
    step();
    bus.wr_rel = 0;
    step();
  endtask

  task automatic test_rd_latency();
    bus.rd_addr = 13'h0123; bus.rd_req = 1;
    step();  // cycle 1
    settle();
    checks++; if (bus.rd_gnt !== 1'b1 || dut.state_q !== OWN_RD) begin failures++; $display("FAIL lat_gnt got=%b/%0d exp=1/%0d", bus.rd_gnt, dut.state_q, OWN_RD); end
    checks++; if (bus.fb_addr !== 13'h0123) begin failures++; $display("FAIL lat_addr got=%h exp=0123", bus.fb_addr); end
    bus.rd_req = 0;
    step();  // cycle 2
    bus.rd_addr = 13'h0456;
    settle();
    checks++; if (bus.rd_gnt !== 1'b0) begin failures++; $display("FAIL lat_gnt_pulse got=%b exp=0", bus.rd_gnt); end
    checks++; if (bus.fb_addr !== 13'h0456) begin failures++; $display("FAIL lat_addr_follow got=%h exp=0456", bus.fb_addr); end
    repeat (256) step();  // cycle 258
    checks++; if (dut.state_q !== OWN_RD) begin failures++; $display("FAIL lat_still_owned got=%0d exp=%0d", dut.state_q, OWN_RD); end
    bus.rd_rel = 1;
    step();  // cycle 259
    bus.rd_rel = 0; bus.rd_addr = 13'h0AAA;
    settle();
    checks++; if (dut.state_q !== TURN) begin failures++; $display("FAIL lat_turn got=%0d exp=%0d", dut.state_q, TURN); end
    checks++; if (bus.fb_addr !== 13'h0456) begin failures++; $display("FAIL lat_addr_hold got=%h exp=0456", bus.fb_addr); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL lat_no_timeout got=%b exp=0", bus.timeout_err); end
    step();  // cycle 260
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL lat_idle got=%0d exp=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_write_isolation();
    bus.rd_addr = 13'h0777; bus.rd_req = 1;
    step();
    bus.rd_req = 0;
    bus.wr_ena = 1; bus.wr_addr = 13'h1FFF; bus.wr_data = 16'hABCD; bus.wr_mask = 4'hF;
    settle();
    checks++; if (bus.fb_wr_ena !== 1'b0) begin failures++; $display("FAIL iso_wr_ena got=%b exp=0", bus.fb_wr_ena); end
    checks++; if (bus.fb_addr !== 13'h0777) begin failures++; $display("FAIL iso_addr got=%h exp=0777", bus.fb_addr); end
    checks++; if (bus.fb_wr_data !== 16'h0 || bus.fb_wr_mask !== 4'h0) begin failures++; $display("FAIL iso_data got=%h/%h exp=0/0", bus.fb_wr_data, bus.fb_wr_mask); end
    bus.wr_rel = 1;
    step();
    bus.wr_rel = 0;
    settle();
    checks++; if (dut.state_q !== OWN_RD || bus.fb_addr !== 13'h0777) begin failures++; $display("FAIL nonowner_rel got=%0d/%h exp=%0d/0777", dut.state_q, bus.fb_addr, OWN_RD); end
    bus.rd_rel = 1;
    step();
    bus.rd_rel = 0;
    step();
    bus.wr_req = 1;
    step();
    bus.wr_req = 0;
    settle();
    checks++; if (bus.wr_gnt !== 1'b1 || bus.fb_wr_ena !== 1'b1) begin failures++; $display("FAIL wr_own got=%b/%b exp=1/1", bus.wr_gnt, bus.fb_wr_ena); end
    checks++; if (bus.fb_addr !== 13'h1FFF || bus.fb_wr_data !== 16'hABCD || bus.fb_wr_mask !== 4'hF) begin failures++; $display("FAIL wr_pass got=%h/%h/%h exp=1fff/abcd/f", bus.fb_addr, bus.fb_wr_data, bus.fb_wr_mask); end
    bus.wr_ena = 0;
    settle();
    checks++; if (bus.fb_wr_ena !== 1'b0) begin failures++; $display("FAIL wr_ena_follow got=%b exp=0", bus.fb_wr_ena); end
    bus.wr_addr = 13'h0042; bus.wr_ena = 1; bus.wr_rel = 1;
    step();
    bus.wr_rel = 0;
    settle();
    checks++; if (bus.fb_wr_ena !== 1'b0 || bus.fb_wr_data !== 16'h0) begin failures++; $display("FAIL turn_no_write got=%b/%h exp=0/0", bus.fb_wr_ena, bus.fb_wr_data); end
    checks++; if (bus.fb_addr !== 13'h0042) begin failures++; $display("FAIL turn_addr_hold got=%h exp=0042", bus.fb_addr); end
    bus.wr_ena = 0;
    step();
  endtask

  task automatic test_reset_mid_own();
    bus.wr_req = 1; bus.wr_ena = 1; bus.wr_addr = 13'h0100;
    step();
    bus.wr_req = 0;
    settle();
    checks++; if (bus.wr_gnt !== 1'b1 || bus.fb_wr_ena !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", bus.wr_gnt, bus.fb_wr_ena); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (bus.fb_wr_ena !== 1'b0 || dut.state_q !== IDLE) begin failures++; $display("FAIL rstmid_async got=%b/%0d exp=0/%0d", bus.fb_wr_ena, dut.state_q, IDLE); end
    checks++; if (bus.wr_gnt !== 1'b0 || bus.fb_addr !== 13'h0) begin failures++; $display("FAIL rstmid_outputs got=%b/%h exp=0/0", bus.wr_gnt, bus.fb_addr); end
    bus.wr_req = 1;
    step();
    step();
    checks++; if (bus.wr_gnt !== 1'b0 || bus.fb_wr_ena !== 1'b0) begin failures++; $display("FAIL rstmid_held got=%b/%b exp=0/0", bus.wr_gnt, bus.fb_wr_ena); end
    rst_n = 1;
    settle();
    checks++; if (bus.wr_gnt !== 1'b0) begin failures++; $display("FAIL rstmid_release got=%b exp=0", bus.wr_gnt); end
    step();
    checks++; if (bus.wr_gnt !== 1'b1 || dut.state_q !== OWN_WR) begin failures++; $display("FAIL rstmid_regrant got=%b/%0d exp=1/%0d", bus.wr_gnt, dut.state_q, OWN_WR); end
    bus.wr_req = 0; bus.wr_ena = 0; bus.wr_rel = 1;
    step();
    bus.wr_rel = 0;
    step();
  endtask

  task automatic test_timeout();
    bus16.wr_req = 1; bus16.wr_ena = 1; bus16.wr_addr = 13'h0333;
    step();  // owned cycle 1
    checks++; if (bus16.wr_gnt !== 1'b1) begin failures++; $display("FAIL tmo_gnt got=%b exp=1", bus16.wr_gnt); end
    bus16.wr_req = 0; bus16.rd_req = 1; bus16.rd_addr = 13'h0555;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (dut16.state_q !== OWN_WR || bus16.timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL tmo_owned_%0d got=%0d/%b exp=%0d/0", i, dut16.state_q, bus16.timeout_err, OWN_WR);
      end
      if (i < 16) step();
    end
    step();  // cycle 17
    checks++; if (dut16.state_q !== TURN || bus16.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_forced got=%0d/%b exp=%0d/1", dut16.state_q, bus16.timeout_err, TURN); end
    checks++; if (bus16.fb_wr_ena !== 1'b0) begin failures++; $display("FAIL tmo_wr_off got=%b exp=0", bus16.fb_wr_ena); end
    step();  // cycle 18
    checks++; if (dut16.state_q !== IDLE || bus16.timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%0d/%b exp=%0d/0", dut16.state_q, bus16.timeout_err, IDLE); end
    step();  // cycle 19
    settle();
    checks++; if (bus16.rd_gnt !== 1'b1 || bus16.fb_addr !== 13'h0555) begin failures++; $display("FAIL tmo_next_rd got=%b/%h exp=1/0555", bus16.rd_gnt, bus16.fb_addr); end
    bus16.rd_req = 0; bus16.wr_ena = 0; bus16.rd_rel = 1;
    step();
    bus16.rd_rel = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rd_latency();
    test_write_isolation();
    test_reset_mid_own();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
